rom_bsram_responder: RTL and testbench

- Memory-side responder for the cartridge ROM/BSRAM bus that the active mapper drives (ROM_ADDR/CE_N/OE_N/WORD, BSRAM_ADDR/D/CE_N/OE_N/WE_N).
- Serves ROM word/byte reads and BSRAM byte reads/writes from a single 16-bit request/acknowledge backend (SDRAM controller port).
- Keeps a one-word ROM line and a one-byte BSRAM line so that repeated accesses cost no backend traffic.
- Sits between the mapper mux and the SDRAM controller.

---
 rtl/snes_mem_pkg.sv | 29 ++
 rtl/resp_line.sv | 43 ++++
 rtl/rom_bsram_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_rom_bsram_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/snes_mem_pkg.sv
// Shared types and helpers for the cartridge ROM/BSRAM responder.
package snes_mem_pkg;

  localparam int MEM_AW = 25;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    REQ_ROM,
    REQ_BSR,
    REQ_WR
  } req_t;

  // Byte reads from an odd address present the addressed byte in bits [7:0].
  function automatic logic [15:0] rom_fmt(input logic [15:0] line,
                                          input logic        word,
                                          input logic        a0);
    return (!word && a0) ? {line[7:0], line[15:8]} : line;
  endfunction

  function automatic logic [7:0] bsr_lane(input logic [15:0] w, input logic a0);
    return a0 ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/resp_line.sv
// One tagged cache line: valid bit, tag compare, fill and write-through.
module resp_line #(
  parameter int TAG_W  = 23,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [TAG_W-1:0]  i_lookup_tag,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_load,
  input  logic [TAG_W-1:0]  i_load_tag,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;

  assign o_hit  = r_valid && (i_lookup_tag == r_tag);
  assign o_data = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // A fill replaces the line outright; write-through only touches a resident tag.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_tag  <= i_load_tag;
      r_data <= i_load_data;
    end else if (i_wr && o_hit) begin
      r_data <= i_wr_data;
    end
  end

endmodule

// File: rtl/rom_bsram_responder.sv
// Memory-side responder: serves mapper ROM/BSRAM strobes from a 16-bit req/ack backend.
module rom_bsram_responder
  import snes_mem_pkg::*;
#(
  parameter logic [MEM_AW-1:0] ROM_BASE   = 25'h0000000,
  parameter logic [MEM_AW-1:0] BSRAM_BASE = 25'h1F00000
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_CE_N,
  input  logic        ROM_OE_N,
  input  logic        ROM_WORD,
  output logic [15:0] ROM_Q,
  input  logic [19:0] BSRAM_ADDR,
  input  logic [7:0]  BSRAM_D,
  input  logic        BSRAM_CE_N,
  input  logic        BSRAM_OE_N,
  input  logic        BSRAM_WE_N,
  output logic [7:0]  BSRAM_Q,
  output logic        BUSY,
  output logic [24:0] MEM_ADDR,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE,
  output logic [15:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA
);

  state_t      r_state;
  req_t        r_cur_type;
  logic [23:0] r_cur_addr;
  logic        r_cur_word;
  logic [7:0]  r_cur_wdata;

  logic        r_rom_pend, r_bsr_pend, r_wr_pend;
  logic        r_rom_renew, r_bsr_renew, r_wr_renew;
  logic [23:0] r_rom_addr;
  logic        r_rom_word;
  logic [19:0] r_bsr_addr;
  logic [19:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_we_n_d;

  logic [15:0] r_rom_q;
  logic [7:0]  r_bsr_q;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [1:0]  r_mem_be;
  logic [24:0] r_mem_addr;
  logic [15:0] r_mem_wdata;

  logic        w_rom_rd, w_bsr_rd, w_wr_edge;
  logic        w_rom_hit, w_bsr_hit;
  logic [15:0] w_rom_line;
  logic [7:0]  w_bsr_line;
  logic        w_any_pend, w_selecting;
  req_t        w_sel;
  logic        w_ack;
  logic        w_rom_inflight, w_bsr_inflight, w_wr_inflight;
  logic        w_rom_dup, w_bsr_dup;
  logic        w_rom_miss, w_bsr_miss;
  logic        w_bsr_conflict;
  logic        w_rom_load, w_bsr_load;
  logic [7:0]  w_rbyte;

  assign w_rom_rd  = !ROM_CE_N && !ROM_OE_N;
  assign w_bsr_rd  = !BSRAM_CE_N && !BSRAM_OE_N && BSRAM_WE_N;
  assign w_wr_edge = r_we_n_d && !BSRAM_WE_N && !BSRAM_CE_N;

  assign w_any_pend  = r_rom_pend || r_bsr_pend || r_wr_pend;
  assign w_selecting = (r_state == IDLE) && w_any_pend;
  assign w_ack       = (r_state == WAIT) && MEM_ACK;

  always_comb begin
    w_sel = REQ_BSR;
    if (r_wr_pend)       w_sel = REQ_WR;
    else if (r_rom_pend) w_sel = REQ_ROM;
  end

  // "In flight" excludes the transaction retiring this edge so a new trigger then is a plain pend.
  assign w_rom_inflight = ((r_state != IDLE) && (r_cur_type == REQ_ROM) && !w_ack) ||
                          (w_selecting && (w_sel == REQ_ROM));
  assign w_bsr_inflight = ((r_state != IDLE) && (r_cur_type == REQ_BSR) && !w_ack) ||
                          (w_selecting && (w_sel == REQ_BSR));
  assign w_wr_inflight  = ((r_state != IDLE) && (r_cur_type == REQ_WR) && !w_ack) ||
                          (w_selecting && (w_sel == REQ_WR));

  assign w_rom_dup = ((r_state != IDLE) && (r_cur_type == REQ_ROM) &&
                      (r_cur_addr[23:1] == ROM_ADDR[23:1])) ||
                     (r_rom_pend && (r_rom_addr[23:1] == ROM_ADDR[23:1]));
  assign w_bsr_dup = ((r_state != IDLE) && (r_cur_type == REQ_BSR) &&
                      (r_cur_addr[19:0] == BSRAM_ADDR)) ||
                     (r_bsr_pend && (r_bsr_addr == BSRAM_ADDR));

  assign w_rom_miss = w_rom_rd && !w_rom_hit && !w_rom_dup;
  assign w_bsr_miss = w_bsr_rd && !w_bsr_hit && !w_bsr_dup;

  // A queued or simultaneous write to the same byte makes the returning read stale.
  assign w_bsr_conflict = (r_wr_pend && (r_wr_addr == r_cur_addr[19:0])) ||
                          (w_wr_edge && (BSRAM_ADDR == r_cur_addr[19:0]));

  assign w_rom_load = w_ack && (r_cur_type == REQ_ROM);
  assign w_bsr_load = w_ack && (r_cur_type == REQ_BSR) && !w_bsr_conflict;
  assign w_rbyte    = bsr_lane(MEM_RDATA, r_cur_addr[0]);

  resp_line #(.TAG_W(23), .DATA_W(16)) u_rom_line (
    .i_clk        (MCLK),
    .i_rst        (RESET),
    .i_lookup_tag (ROM_ADDR[23:1]),
    .o_hit        (w_rom_hit),
    .o_data       (w_rom_line),
    .i_load       (w_rom_load),
    .i_load_tag   (r_cur_addr[23:1]),
    .i_load_data  (MEM_RDATA),
    .i_wr         (1'b0),
    .i_wr_data    (16'h0000)
  );

  resp_line #(.TAG_W(20), .DATA_W(8)) u_bsr_line (
    .i_clk        (MCLK),
    .i_rst        (RESET),
    .i_lookup_tag (BSRAM_ADDR),
    .o_hit        (w_bsr_hit),
    .o_data       (w_bsr_line),
    .i_load       (w_bsr_load),
    .i_load_tag   (r_cur_addr[19:0]),
    .i_load_data  (w_rbyte),
    .i_wr         (w_wr_edge),
    .i_wr_data    (BSRAM_D)
  );

  // Request latches and in-flight snapshot (data path, not reset)
  always_ff @(posedge MCLK) begin
    if (w_rom_miss) begin
      r_rom_addr <= ROM_ADDR;
      r_rom_word <= ROM_WORD;
    end
    if (w_bsr_miss) r_bsr_addr <= BSRAM_ADDR;
    if (w_wr_edge) begin
      r_wr_addr <= BSRAM_ADDR;
      r_wr_data <= BSRAM_D;
    end
    if (w_selecting) begin
      case (w_sel)
        REQ_WR: begin
          r_cur_addr  <= {4'h0, r_wr_addr};
          r_cur_wdata <= r_wr_data;
        end
        REQ_ROM: begin
          r_cur_addr <= r_rom_addr;
          r_cur_word <= r_rom_word;
        end
        default: r_cur_addr <= {4'h0, r_bsr_addr};
      endcase
    end
  end

  // Control: pend flags, FSM, backend outputs, read-data outputs
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cur_type  <= REQ_ROM;
      r_rom_pend  <= 1'b0;
      r_bsr_pend  <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rom_renew <= 1'b0;
      r_bsr_renew <= 1'b0;
      r_wr_renew  <= 1'b0;
      r_we_n_d    <= 1'b1;
      r_rom_q     <= 16'h0000;
      r_bsr_q     <= 8'h00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
    end else begin
      r_we_n_d <= BSRAM_WE_N;

      case (r_state)
        IDLE: begin
          if (w_any_pend) begin
            r_cur_type <= w_sel;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_req <= 1'b1;
          r_state   <= WAIT;
          if (r_cur_type == REQ_ROM) begin
            r_mem_addr <= ROM_BASE + {1'b0, r_cur_addr[23:1], 1'b0};
            r_mem_be   <= 2'b11;
            r_mem_we   <= 1'b0;
          end else begin
            r_mem_addr <= BSRAM_BASE + {5'b0, r_cur_addr[19:0]};
            r_mem_be   <= r_cur_addr[0] ? 2'b10 : 2'b01;
            r_mem_we   <= (r_cur_type == REQ_WR);
            if (r_cur_type == REQ_WR) r_mem_wdata <= {r_cur_wdata, r_cur_wdata};
          end
        end
        default: begin
          if (MEM_ACK) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            case (r_cur_type)
              REQ_ROM: begin
                r_rom_pend  <= r_rom_renew;
                r_rom_renew <= 1'b0;
              end
              REQ_BSR: begin
                r_bsr_pend  <= r_bsr_renew;
                r_bsr_renew <= 1'b0;
              end
              default: begin
                r_wr_pend  <= r_wr_renew;
                r_wr_renew <= 1'b0;
              end
            endcase
          end
        end
      endcase

      // New triggers take precedence over the retire-clear above.
      if (w_rom_miss) begin
        r_rom_pend <= 1'b1;
        if (w_rom_inflight) r_rom_renew <= 1'b1;
      end
      if (w_bsr_miss) begin
        r_bsr_pend <= 1'b1;
        if (w_bsr_inflight) r_bsr_renew <= 1'b1;
      end
      if (w_wr_edge) begin
        r_wr_pend <= 1'b1;
        if (w_wr_inflight) r_wr_renew <= 1'b1;
      end

      if (w_rom_load) r_rom_q <= rom_fmt(MEM_RDATA, r_cur_word, r_cur_addr[0]);
      if (w_rom_rd && w_rom_hit) r_rom_q <= rom_fmt(w_rom_line, ROM_WORD, ROM_ADDR[0]);

      if (w_bsr_load) r_bsr_q <= w_rbyte;
      if (w_bsr_rd && w_bsr_hit) r_bsr_q <= w_bsr_line;
      if (w_wr_edge && w_bsr_hit) r_bsr_q <= BSRAM_D;
    end
  end

  assign BUSY      = w_any_pend || (r_state != IDLE);
  assign ROM_Q     = r_rom_q;
  assign BSRAM_Q   = r_bsr_q;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_BE    = r_mem_be;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;

endmodule

// File: tb/tb_rom_bsram_responder.sv
// Directed bench for rom_bsram_responder with a hand-driven backend.
module tb_rom_bsram_responder;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [23:0] ROM_ADDR;
  logic        ROM_CE_N, ROM_OE_N, ROM_WORD;
  logic [15:0] ROM_Q;
  logic [19:0] BSRAM_ADDR;
  logic [7:0]  BSRAM_D;
  logic        BSRAM_CE_N, BSRAM_OE_N, BSRAM_WE_N;
  logic [7:0]  BSRAM_Q;
  logic        BUSY;
  logic [24:0] MEM_ADDR;
  logic        MEM_REQ, MEM_WE;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0;
  int n0;
  logic r_req_d = 1'b0;

  rom_bsram_responder dut (
    .MCLK(MCLK), .RESET(RESET),
    .ROM_ADDR(ROM_ADDR), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
    .ROM_WORD(ROM_WORD), .ROM_Q(ROM_Q),
    .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_D(BSRAM_D), .BSRAM_CE_N(BSRAM_CE_N),
    .BSRAM_OE_N(BSRAM_OE_N), .BSRAM_WE_N(BSRAM_WE_N), .BSRAM_Q(BSRAM_Q),
    .BUSY(BUSY), .MEM_ADDR(MEM_ADDR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 MCLK = ~MCLK;

  // Count request rising edges, sampled mid-cycle.
  always @(negedge MCLK) begin
    if (MEM_REQ && !r_req_d) n_req <= n_req + 1;
    r_req_d <= MEM_REQ;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!MEM_REQ && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'b0, MEM_REQ}, 32'd1);
  endtask

  task automatic ack(input logic [15:0] d);
    MEM_ACK   = 1'b1;
    MEM_RDATA = d;
    tick();
    MEM_ACK   = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    ROM_ADDR = '0; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_WORD = 1'b1;
    BSRAM_ADDR = '0; BSRAM_D = '0;
    BSRAM_CE_N = 1'b1; BSRAM_OE_N = 1'b1; BSRAM_WE_N = 1'b1;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    tick(); tick();
    chk("rst_romq", ROM_Q, 0);
    chk("rst_bsrq", BSRAM_Q, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_be", MEM_BE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_wdata", MEM_WDATA, 0);
    RESET = 1'b0;
    tick();

    // 1: word miss at 0x000100
    ROM_ADDR = 24'h000100; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
    wait_req("t1");
    chk("t1_addr", MEM_ADDR, 25'h0000100);
    chk("t1_be", MEM_BE, 2'b11);
    chk("t1_we", MEM_WE, 0);
    tick(); tick();
    chk("t1_req_hold", MEM_REQ, 1);
    chk("t1_busy", BUSY, 1);
    ack(16'hA55A);
    chk("t1_romq", ROM_Q, 16'hA55A);
    chk("t1_req_drop", MEM_REQ, 0);
    tick();
    chk("t1_busy_low", BUSY, 0);

    // 2: odd byte hit in the same word
    n0 = n_req;
    ROM_ADDR = 24'h000101; ROM_WORD = 1'b0;
    tick();
    chk("t2_romq", ROM_Q, 16'h5AA5);
    tick(); tick();
    chk("t2_noreq", n_req, n0);
    chk("t2_busy", BUSY, 0);
    ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;

    // 3: BSRAM write 0x3C to 0x00005
    n0 = n_req;
    BSRAM_ADDR = 20'h00005; BSRAM_D = 8'h3C; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
    wait_req("t3");
    chk("t3_addr", MEM_ADDR, 25'h1F00005);
    chk("t3_we", MEM_WE, 1);
    chk("t3_be", MEM_BE, 2'b10);
    chk("t3_wdata", MEM_WDATA, 16'h3C3C);
    ack(16'h0000);
    tick(); tick(); tick();
    chk("t3_one_req", n_req, n0 + 1);
    BSRAM_WE_N = 1'b1; BSRAM_CE_N = 1'b1;
    tick();

    // 4: ROM miss and BSRAM write edge together
    n0 = n_req;
    ROM_ADDR = 24'h000200; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
    BSRAM_ADDR = 20'h00006; BSRAM_D = 8'h77; BSRAM_CE_N = 1'b0; BSRAM_WE_N = 1'b0;
    wait_req("t4a");
    chk("t4_first_we", MEM_WE, 1);
    chk("t4_first_addr", MEM_ADDR, 25'h1F00006);
    chk("t4_first_be", MEM_BE, 2'b01);
    chk("t4_first_wdata", MEM_WDATA, 16'h7777);
    ack(16'h0000);
    chk("t4_busy_mid", BUSY, 1);
    wait_req("t4b");
    chk("t4_second_we", MEM_WE, 0);
    chk("t4_second_addr", MEM_ADDR, 25'h0000200);
    chk("t4_second_be", MEM_BE, 2'b11);
    ack(16'h1234);
    chk("t4_romq", ROM_Q, 16'h1234);
    tick();
    chk("t4_busy_done", BUSY, 0);
    chk("t4_two_req", n_req, n0 + 2);
    ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; BSRAM_WE_N = 1'b1; BSRAM_CE_N = 1'b1;
    tick();

    // BSRAM read miss, write-through, then read hit
    BSRAM_ADDR = 20'h00006; BSRAM_CE_N = 1'b0; BSRAM_OE_N = 1'b0;
    wait_req("rd");
    chk("rd_addr", MEM_ADDR, 25'h1F00006);
    chk("rd_we", MEM_WE, 0);
    chk("rd_be", MEM_BE, 2'b01);
    ack(16'h9977);
    chk("rd_bsrq", BSRAM_Q, 8'h77);
    BSRAM_OE_N = 1'b1; BSRAM_WE_N = 1'b0; BSRAM_D = 8'h55;
    tick();
    chk("wt_bsrq", BSRAM_Q, 8'h55);
    wait_req("wt");
    chk("wt_we", MEM_WE, 1);
    ack(16'h0000);
    BSRAM_WE_N = 1'b1;
    tick();
    n0 = n_req;
    BSRAM_OE_N = 1'b0;
    tick();
    chk("hit_bsrq", BSRAM_Q, 8'h55);
    tick(); tick();
    chk("hit_noreq", n_req, n0);
    BSRAM_OE_N = 1'b1; BSRAM_CE_N = 1'b1;

    // 5: reset while waiting, then a late ack
    ROM_ADDR = 24'h000300; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
    wait_req("t5");
    tick();
    RESET = 1'b1; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
    tick();
    chk("t5_req_drop", MEM_REQ, 0);
    chk("t5_romq_rst", ROM_Q, 0);
    chk("t5_busy", BUSY, 0);
    RESET = 1'b0;
    ack(16'hBEEF);
    chk("t5_late_romq", ROM_Q, 0);
    chk("t5_late_req", MEM_REQ, 0);
    tick();
    n0 = n_req;
    ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
    wait_req("t5r");
    chk("t5r_addr", MEM_ADDR, 25'h0000300);
    ack(16'h4321);
    chk("t5r_romq", ROM_Q, 16'h4321);
    chk("t5r_new_req", n_req, n0 + 1);

    // Address change while a ROM fetch waits
    ROM_ADDR = 24'h000400;
    wait_req("t6a");
    chk("t6a_addr", MEM_ADDR, 25'h0000400);
    ROM_ADDR = 24'h000500;
    tick();
    ack(16'h1111);
    chk("t6_romq_first", ROM_Q, 16'h1111);
    chk("t6_busy", BUSY, 1);
    wait_req("t6b");
    chk("t6b_addr", MEM_ADDR, 25'h0000500);
    ack(16'h2222);
    chk("t6_romq_second", ROM_Q, 16'h2222);
    tick();
    chk("t6_busy_done", BUSY, 0);
    ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
